mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
Bus-initiator block that drives the data-memory port (read/write strobes, address, write data, word/byte select) to perform block copy or block fill without CPU involvement. Sits beside the pipeline's MEM stage on the data-memory bus. An external arbiter grants the bus to it via bus_grant. Memory read data is combinational in the same cycle as the address. Memory writes commit at the next posedge.

Parameters:
LEN_W, 11, width of the transfer length and completed-transfer counter (covers 2048 bytes = full 512-word memory)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  one-cycle request; sampled only in IDLE
src_addr  in  32  source byte address (ignored in fill mode)
dst_addr  in  32  destination byte address
len  in  LEN_W  number of units to move (words or bytes)
byte_mode  in  1  0 = word transfers, 1 = byte transfers
fill_mode  in  1  1 = write fill_value, no reads
fill_value  in  32  fill data (byte mode uses [7:0] only)
abort  in  1  synchronous cancel of an active transfer
bus_grant  in  1  arbiter grant; the engine issues no strobe while low
mem_rdata  in  32  memory read data (zero-extended byte in byte mode)
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_addr  out  32  byte address
mem_wdata  out  32  write data
mem_byte  out  1  word/byte select, 1 = byte
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
xfer_count  out  LEN_W  completed writes of the current or last transfer

Behaviour:
- Reset: state IDLE. mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte, busy, done, xfer_count, and all internal registers are 0. Reset has priority over everything and aborts any transfer mid-operation. A write strobe is never asserted in the cycle where reset is sampled high.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: on start=1, latch src/dst/len/byte_mode/fill_mode/fill_value and clear xfer_count.
  - len=0: go to DONE.
  - len>0 and fill_mode=1: go to WRITE.
  - len>0 and fill_mode=0: go to READ.
  - start outside IDLE (including DONE) is ignored.
- READ: mem_rd = bus_grant, mem_addr = current src. At a posedge with bus_grant=1, capture mem_rdata into the data register and go to WRITE. With bus_grant=0, hold state.
- WRITE: mem_wr = bus_grant, mem_addr = current dst. mem_wdata = data register (copy) or latched fill_value (fill).
  - At a posedge with bus_grant=1: xfer_count+1, remaining-1, src and dst each advance by 4 (word) or 1 (byte).
  - If remaining reaches 0, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
  - With bus_grant=0, hold state.
- DONE: done=1 for exactly this one cycle, then IDLE.
- busy=1 in READ, WRITE and DONE; 0 in IDLE.
- Outputs outside READ/WRITE: mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0. mem_byte = latched byte_mode while busy, 0 in IDLE.
- Strobes are gated combinationally by bus_grant; address and wdata stay stable while stalled.
- Latency with continuous grant: copy takes 2*len cycles in READ/WRITE; fill takes len cycles; plus 1 DONE cycle. Start-to-done = 2*len+1 (copy) or len+1 (fill) cycles after the start-sampling edge.
- Address arithmetic is modulo 2^32 and wraps silently. Word mode passes addr[1:0] through unchanged; the memory ignores them for word access.
- Byte copy writes only mem_rdata[7:0] significance. The data register holds the zero-extended byte as returned.
- abort=1 in READ/WRITE/DONE: go to IDLE next cycle, no done pulse, xfer_count keeps its value. Abort in the same cycle as a granted write: that write still commits and is counted. abort in IDLE has no effect; start wins if both are high in IDLE.
- xfer_count holds after DONE until the next accepted start.

Test Plan:
- Word copy: preload 0x100..0x10C = 11,22,33,44. start, src=0x100, dst=0x200, len=4, byte_mode=0, grant=1 -> 0x200..0x20C equal the source; done pulses once exactly 9 cycles after start; xfer_count=4; busy then 0.
- Byte copy: word 0x100 = 0xAABBCCDD. src=0x101, dst=0x302, len=3, byte_mode=1 -> bytes at 0x302,0x303,0x304 = CC,BB,AA; other bytes of 0x300/0x304 unchanged; mem_byte=1 throughout.
- Fill with len=0: fill_mode=1, fill_value=0xDEADBEEF, dst=0x40, len=5 -> 0x40..0x50 = 0xDEADBEEF, 6 cycles to done. A second run with len=0 -> no strobes, done 1 cycle after start, xfer_count=0.
- Grant stall: copy len=2 with bus_grant low for 3 cycles during first WRITE -> mem_wr=0 while stalled, addr/wdata stable, final memory correct, done delayed exactly 3 cycles.
- Abort/reset mid-operation: abort in second READ of a len=4 copy -> IDLE, no done, xfer_count=1. Repeat with reset instead -> all outputs 0, xfer_count=0, no further writes.
- start while busy: pulse start with different params during a transfer -> ignored, original transfer completes unchanged.

Source files
------------

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_engine
//  Purpose  : Bus-initiator block copy / block fill engine for the data-memory
//             port. It alternates READ and WRITE (copy) or issues back-to-back
//             WRITEs (fill). Strobes are gated by the arbiter grant.
//  Revision : 1.0  initial release
// ============================================================================
module mem_copy_engine #(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             byte_mode,
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
    input  logic             abort,
    input  logic             bus_grant,
    input  logic [31:0]      mem_rdata,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_byte,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] xfer_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);

    logic [1:0]       r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_remaining;
    logic             r_byte_mode;
    logic             r_fill_mode;
    logic [31:0]      r_fill_value;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_xfer_count;

    logic [31:0]      w_step;
    logic [31:0]      w_fill_data;

    assign w_step      = r_byte_mode ? 32'd1 : 32'd4;
    // Byte fill only carries the low byte; upper lanes are driven as zero.
    assign w_fill_data = r_byte_mode ? {24'd0, r_fill_value[7:0]} : r_fill_value;

    // Transfer sequencer: parameter latch, data capture, pointer/count update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_remaining  <= '0;
            r_byte_mode  <= 1'b0;
            r_fill_mode  <= 1'b0;
            r_fill_value <= '0;
            r_data       <= '0;
            r_xfer_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_remaining  <= len;
                        r_byte_mode  <= byte_mode;
                        r_fill_mode  <= fill_mode;
                        r_fill_value <= fill_value;
                        r_xfer_count <= '0;
                        if (len == c_LEN_ZERO) begin
                            r_state <= c_ST_DONE;
                        end else if (fill_mode) begin
                            r_state <= c_ST_WRITE;
                        end else begin
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_READ: begin
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (bus_grant) begin
                        r_data  <= mem_rdata;
                        r_state <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    // A granted write commits even if abort arrives with it.
                    if (bus_grant) begin
                        r_xfer_count <= r_xfer_count + c_LEN_ONE;
                        r_remaining  <= r_remaining - c_LEN_ONE;
                        r_src        <= r_src + w_step;
                        r_dst        <= r_dst + w_step;
                        if (r_remaining == c_LEN_ONE) begin
                            r_state <= c_ST_DONE;
                        end else if (!r_fill_mode) begin
                            r_state <= c_ST_READ;
                        end
                    end
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decoded from state; strobes gated by grant and suppressed
    // while reset is being sampled so no write lands on the reset edge.
    always_comb begin
        mem_rd     = (r_state == c_ST_READ)  && bus_grant && !reset;
        mem_wr     = (r_state == c_ST_WRITE) && bus_grant && !reset;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (r_state == c_ST_READ) begin
            mem_addr = r_src;
        end else if (r_state == c_ST_WRITE) begin
            mem_addr  = r_dst;
            mem_wdata = r_fill_mode ? w_fill_data : r_data;
        end
        busy       = (r_state != c_ST_IDLE);
        mem_byte   = busy && r_byte_mode;
        done       = (r_state == c_ST_DONE) && !abort;
        xfer_count = r_xfer_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_engine
//  Purpose  : Directed and randomized bench for mem_copy_engine with a byte
//             memory and a sequential copy/fill reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [10:0] len = '0;
    logic        byte_mode = 1'b0;
    logic        fill_mode = 1'b0;
    logic [31:0] fill_value = '0;
    logic        abort = 1'b0;
    logic        bus_grant = 1'b1;
    logic [31:0] mem_rdata;
    logic        mem_rd, mem_wr, mem_byte, busy, done;
    logic [31:0] mem_addr, mem_wdata;
    logic [10:0] xfer_count;

    logic [7:0]  mem     [0:2047];
    logic [7:0]  ref_mem [0:2047];
    logic [10:0] rd_a, rd_wa;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int wr_seen = 0;
    int rd_seen = 0;

    mem_copy_engine #(.LEN_W(11)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .byte_mode(byte_mode),
        .fill_mode(fill_mode), .fill_value(fill_value), .abort(abort),
        .bus_grant(bus_grant), .mem_rdata(mem_rdata), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte(mem_byte), .busy(busy), .done(done), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    // Little-endian memory with combinational read; only addr[10:0] decoded.
    always_comb begin
        rd_a  = mem_addr[10:0];
        rd_wa = {mem_addr[10:2], 2'b00};
        if (mem_byte) mem_rdata = {24'd0, mem[rd_a]};
        else          mem_rdata = {mem[rd_wa + 11'd3], mem[rd_wa + 11'd2], mem[rd_wa + 11'd1], mem[rd_wa]};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a negedge: a write strobe seen now commits at the next posedge.
    task automatic sample_bus();
        logic [10:0] a;
        if (mem_rd === 1'b1) rd_seen++;
        if (mem_wr === 1'b1) begin
            wr_seen++;
            a = mem_addr[10:0];
            if (mem_byte) mem[a] = mem_wdata[7:0];
            else begin
                a = {a[10:2], 2'b00};
                {mem[a + 11'd3], mem[a + 11'd2], mem[a + 11'd1], mem[a]} = mem_wdata;
            end
        end
    endtask

    task automatic poke_word(input logic [10:0] addr, input logic [31:0] v);
        {mem[addr + 11'd3], mem[addr + 11'd2], mem[addr + 11'd1], mem[addr]} = v;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
    endtask

    // Reference: perform the transfer unit by unit in program order.
    task automatic ref_apply(input logic [31:0] src, input logic [31:0] dst, input int ln,
                             input bit bm, input bit fm, input logic [31:0] fv);
        logic [31:0] s, d, v, step;
        logic [10:0] a;
        step = bm ? 32'd1 : 32'd4;
        for (int i = 0; i < ln; i++) begin
            s = src + 32'(i) * step;
            d = dst + 32'(i) * step;
            if (bm) begin
                v = fm ? {24'd0, fv[7:0]} : {24'd0, ref_mem[s[10:0]]};
                ref_mem[d[10:0]] = v[7:0];
            end else begin
                a = {s[10:2], 2'b00};
                v = fm ? fv : {ref_mem[a + 11'd3], ref_mem[a + 11'd2], ref_mem[a + 11'd1], ref_mem[a]};
                a = {d[10:2], 2'b00};
                {ref_mem[a + 11'd3], ref_mem[a + 11'd2], ref_mem[a + 11'd1], ref_mem[a]} = v;
            end
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check({tag, "_mem_diffs"}, 64'(diffs), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 sample_bus();
        end
    endtask

    // gmode: 0 grant held, 1 random grant, 2 grant low in cycles 2..4,
    //        3 grant held plus a conflicting start pulse in cycle 3.
    task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int ln, input bit bm, input bit fm, input logic [31:0] fv,
                            input int gmode, input int exp_cycles);
        int k = 0, done_cnt = 0, done_k = 0, viol_strobe = 0, viol_byte = 0;
        logic [31:0] hold_addr = '0, hold_wdata = '0;
        snapshot();
        ref_apply(src, dst, ln, bm, fm, fv);
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; len = ln[10:0];
        byte_mode = bm; fill_mode = fm; fill_value = fv; bus_grant = 1'b1;
        wr_seen = 0; rd_seen = 0;
        #1 sample_bus();
        @(posedge clk);
        while (k < 3000 && !(done_cnt > 0 && k >= done_k + 2)) begin
            k++;
            @(negedge clk);
            start = 1'b0;
            if (gmode == 3 && k == 3) begin
                start = 1'b1; src_addr = 32'h0000_0700; dst_addr = 32'h0000_0040;
                len = 11'd7; fill_mode = ~fm; byte_mode = ~bm; fill_value = 32'h5A5A_5A5A;
            end
            if (gmode == 1)                     bus_grant = ($urandom_range(0, 3) != 0);
            else if (gmode == 2 && k >= 2 && k <= 4) bus_grant = 1'b0;
            else                                bus_grant = 1'b1;
            #1;
            if (!bus_grant && (mem_rd || mem_wr)) viol_strobe++;
            if (busy && (mem_byte !== bm)) viol_byte++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done_k = k;
            end
            if (gmode == 2 && k == 2) begin hold_addr = mem_addr; hold_wdata = mem_wdata; end
            if (gmode == 2 && k == 4) begin
                check({tag, "_stall_wr"}, 64'(mem_wr), 64'd0);
                check({tag, "_stall_addr"}, 64'(mem_addr), 64'(hold_addr));
                check({tag, "_stall_wdata"}, 64'(mem_wdata), 64'(hold_wdata));
            end
            sample_bus();
        end
        bus_grant = 1'b1;
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        if (exp_cycles >= 0) check({tag, "_latency"}, 64'(done_k), 64'(exp_cycles));
        check({tag, "_xfer_count"}, 64'(xfer_count), 64'(ln));
        check({tag, "_writes"}, 64'(wr_seen), 64'(ln));
        check({tag, "_reads"}, 64'(rd_seen), fm ? 64'd0 : 64'(ln));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_idle_bus"}, 64'({mem_addr, mem_wdata, mem_byte}), 64'd0);
        check({tag, "_strobe_no_grant"}, 64'(viol_strobe), 64'd0);
        check({tag, "_mem_byte"}, 64'(viol_byte), 64'd0);
        check_mem(tag);
    endtask

    initial begin
        int dseen;
        logic [31:0] rs, rd;
        int rl;
        bit rb, rf;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

        // Reset state
        idle_cycles(2);
        check("reset_outputs", 64'({mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte, busy, done, xfer_count}), 64'd0);
        @(negedge clk); reset = 1'b0;
        #1 sample_bus();
        abort = 1'b1; idle_cycles(1); abort = 1'b0;
        check("abort_in_idle", 64'({busy, done}), 64'd0);

        // Word copy
        poke_word(11'h100, 32'd11); poke_word(11'h104, 32'd22);
        poke_word(11'h108, 32'd33); poke_word(11'h10C, 32'd44);
        run_xfer("word_copy", 32'h100, 32'h200, 4, 1'b0, 1'b0, 32'h0, 0, 9);

        // Byte copy with unaligned source and destination
        poke_word(11'h100, 32'hAABB_CCDD); poke_word(11'h300, 32'h1234_5678);
        poke_word(11'h304, 32'h9ABC_DEF0);
        run_xfer("byte_copy", 32'h101, 32'h302, 3, 1'b1, 1'b0, 32'h0, 0, 7);
        check("byte_copy_w300", 64'({mem[11'h303], mem[11'h302], mem[11'h301], mem[11'h300]}), 64'h BBCC_5678);
        check("byte_copy_w304", 64'({mem[11'h307], mem[11'h306], mem[11'h305], mem[11'h304]}), 64'h 9ABC_DEAA);

        // Fills, including zero length and a byte fill wrapping the 32-bit space
        run_xfer("word_fill", 32'h0, 32'h40, 5, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 6);
        run_xfer("zero_len", 32'h0, 32'h40, 0, 1'b0, 1'b1, 32'h1111_1111, 0, 1);
        run_xfer("byte_fill_wrap", 32'h0, 32'hFFFF_FFFE, 4, 1'b1, 1'b1, 32'h0000_0077, 0, 5);
        run_xfer("word_copy_wrap", 32'hFFFF_FFF8, 32'h0000_0400, 3, 1'b0, 1'b0, 32'h0, 0, 7);

        // Grant stall during first write: three extra cycles
        run_xfer("grant_stall", 32'h180, 32'h280, 2, 1'b0, 1'b0, 32'h0, 2, 8);

        // Conflicting start while busy is ignored
        run_xfer("start_busy", 32'h500, 32'h580, 3, 1'b0, 1'b0, 32'h0, 3, 7);

        // Abort during the second READ
        snapshot(); ref_apply(32'h600, 32'h680, 1, 1'b0, 1'b0, 32'h0);
        @(negedge clk); start = 1'b1; src_addr = 32'h600; dst_addr = 32'h680; len = 11'd4;
        byte_mode = 1'b0; fill_mode = 1'b0; wr_seen = 0; dseen = 0;
        #1 sample_bus();
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); start = 1'b0; abort = (k == 3);
            #1 if (done === 1'b1) dseen++;
            sample_bus();
        end
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_done", 64'(dseen), 64'd0);
        check("abort_xfer_count", 64'(xfer_count), 64'd1);
        check("abort_writes", 64'(wr_seen), 64'd1);
        check_mem("abort");

        // Reset during the second READ
        snapshot(); ref_apply(32'h700, 32'h780, 1, 1'b0, 1'b0, 32'h0);
        @(negedge clk); start = 1'b1; src_addr = 32'h700; dst_addr = 32'h780; len = 11'd4;
        wr_seen = 0; dseen = 0;
        #1 sample_bus();
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); start = 1'b0; reset = (k == 3);
            #1 if (done === 1'b1) dseen++;
            if (k == 4) check("reset_mid_outputs",
                64'({mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte, busy, done, xfer_count}), 64'd0);
            sample_bus();
        end
        reset = 1'b0;
        check("reset_no_done", 64'(dseen), 64'd0);
        check("reset_writes", 64'(wr_seen), 64'd1);
        check_mem("reset");

        // Randomized transfers with random grant
        for (int t = 0; t < 8; t++) begin
            rb = 1'($urandom_range(0, 1));
            rf = 1'($urandom_range(0, 1));
            rl = int'($urandom_range(1, 10));
            rs = $urandom_range(0, 2047);
            rd = $urandom_range(0, 2047);
            if (!rb) begin rs[1:0] = 2'b00; rd[1:0] = 2'b00; end
            run_xfer($sformatf("rand%0d", t), rs, rd, rl, rb, rf, $urandom, 1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
